// File: rtl/pong_game_pkg.sv
// Shared types for the pong match logic: game state encoding and score limits.
package pong_game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    POINT     = 3'd4,
    GAME_OVER = 3'd5
  } game_state_t;

  localparam logic [3:0] SCORE_MAX = 4'd15;

  function automatic logic [3:0] score_inc(input logic [3:0] v);
    return (v == SCORE_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/game_flow_controller_edge_detector.sv
// Registered rising-edge detector: rise pulses one cycle after in goes 0->1.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic prev;

  // A level already high while reset is held counts as seen, so it cannot
  // produce a spurious edge when reset is released.
  always_ff @(posedge clk) begin
    prev <= in;
    if (!rst) begin
      rise <= 1'b0;
    end else begin
      rise <= in & ~prev;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Match-level sequencer: serve/play/pause/point/game-over flow, goal detection
// from the ball X position and saturating score keeping for both players.
module game_flow_controller
  import pong_game_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_TICKS  = 60,
  parameter int unsigned POINT_TICKS  = 90,
  parameter logic [10:0] GOAL_LEFT_X  = 11'd0,
  parameter logic [10:0] GOAL_RIGHT_X = 11'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start,
  input  logic        pause,
  input  logic [10:0] x_ball,
  output logic        ball_run,
  output logic        ball_serve,
  output logic        serve_dir,
  output logic [3:0]  player1_score,
  output logic [3:0]  player2_score,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state
);

  localparam int unsigned MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] SERVE_END = CW'(SERVE_TICKS);
  localparam logic [CW-1:0] POINT_END = CW'(POINT_TICKS);
  localparam logic [3:0]    WIN_VAL   = 4'(WIN_SCORE);

  game_state_t cur_state, nxt_state;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    p1_n, p2_n;
  logic          dir_n, winner_n, serve_n, run_n, over_n;
  logic          start_edge, pause_edge;
  logic          p1_won, p2_won;

  edge_detector u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (start),
    .rise (start_edge)
  );

  edge_detector u_pause_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (pause),
    .rise (pause_edge)
  );

  assign state   = cur_state;
  assign cnt_inc = cnt + CW'(1);
  assign p1_won  = (player1_score >= WIN_VAL);
  assign p2_won  = (player2_score >= WIN_VAL);

  always_comb begin
    nxt_state = cur_state;
    cnt_n     = cnt;
    p1_n      = player1_score;
    p2_n      = player2_score;
    dir_n     = serve_dir;
    winner_n  = winner;

    case (cur_state)
      IDLE: begin
        if (start_edge) begin
          nxt_state = SERVE;
          p1_n      = '0;
          p2_n      = '0;
          dir_n     = 1'b0;
        end
      end
      SERVE: begin
        if (timing_tick) begin
          if (cnt_inc == SERVE_END) nxt_state = PLAY;
          else                      cnt_n     = cnt_inc;
        end
      end
      PLAY: begin
        if (timing_tick && (x_ball <= GOAL_LEFT_X)) begin
          p2_n      = score_inc(player2_score);
          dir_n     = 1'b1;
          nxt_state = POINT;
        end else if (timing_tick && (x_ball >= GOAL_RIGHT_X)) begin
          p1_n      = score_inc(player1_score);
          dir_n     = 1'b0;
          nxt_state = POINT;
        end else if (pause_edge) begin
          nxt_state = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_edge) nxt_state = PLAY;
      end
      POINT: begin
        if (timing_tick) begin
          if (cnt_inc == POINT_END) begin
            if (p1_won || p2_won) begin
              nxt_state = GAME_OVER;
              winner_n  = ~p1_won;
            end else begin
              nxt_state = SERVE;
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      GAME_OVER: begin
        if (start_edge) begin
          nxt_state = SERVE;
          p1_n      = '0;
          p2_n      = '0;
          dir_n     = 1'b0;
          winner_n  = 1'b0;
        end
      end
      default: nxt_state = IDLE;
    endcase

    // Both timed states start counting from zero on entry.
    if ((nxt_state != cur_state) && ((nxt_state == SERVE) || (nxt_state == POINT))) begin
      cnt_n = '0;
    end

    serve_n = (nxt_state == SERVE) && (cur_state != SERVE);
    run_n   = (nxt_state == PLAY);
    over_n  = (nxt_state == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state     <= IDLE;
      cnt           <= '0;
      player1_score <= '0;
      player2_score <= '0;
      serve_dir     <= 1'b0;
      winner        <= 1'b0;
      ball_serve    <= 1'b0;
      ball_run      <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      cur_state     <= nxt_state;
      cnt           <= cnt_n;
      player1_score <= p1_n;
      player2_score <= p2_n;
      serve_dir     <= dir_n;
      winner        <= winner_n;
      ball_serve    <= serve_n;
      ball_run      <= run_n;
      game_over     <= over_n;
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller with short serve/point timings.
module tb_game_flow_controller;
  import pong_game_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        timing_tick = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [10:0] x_ball = 11'd512;
  logic        ball_run, ball_serve, serve_dir, game_over, winner;
  logic [3:0]  player1_score, player2_score;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  game_flow_controller #(
    .WIN_SCORE   (3),
    .SERVE_TICKS (2),
    .POINT_TICKS (3),
    .GOAL_LEFT_X (11'd0),
    .GOAL_RIGHT_X(11'd1023)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .timing_tick  (timing_tick),
    .start        (start),
    .pause        (pause),
    .x_ball       (x_ball),
    .ball_run     (ball_run),
    .ball_serve   (ball_serve),
    .serve_dir    (serve_dir),
    .player1_score(player1_score),
    .player2_score(player2_score),
    .game_over    (game_over),
    .winner       (winner),
    .state        (state)
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // {state, run, serve, dir, p1, p2, game_over, winner}
  function automatic logic [15:0] snap(input logic [2:0] st, input logic run, input logic srv,
                                       input logic dir, input logic [3:0] p1, input logic [3:0] p2,
                                       input logic go, input logic win);
    return {st, run, srv, dir, p1, p2, go, win};
  endfunction

  function automatic logic [15:0] obs_snap();
    return {state, ball_run, ball_serve, serve_dir, player1_score, player2_score, game_over, winner};
  endfunction

  task automatic cyc(input logic tk, input logic st, input logic ps, input logic [10:0] x);
    timing_tick = tk;
    start       = st;
    pause       = ps;
    x_ball      = x;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_chk(input logic tk, input logic st, input logic ps, input logic [10:0] x,
                         input string tag, input logic [15:0] e);
    exp_t got;
    sb.push_back('{tag, e});
    cyc(tk, st, ps, x);
    got = sb.pop_front();
    check_val(got.tag, obs_snap(), got.v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and first serve
    rst = 1'b0;
    cyc(0, 0, 0, 512);
    cyc_chk(0, 0, 0, 512, "reset", snap(IDLE, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    cyc(0, 0, 0, 512);
    cyc_chk(0, 1, 0, 512, "start_latency", snap(IDLE, 0, 0, 0, 0, 0, 0, 0));
    cyc_chk(0, 1, 0, 512, "serve_entry", snap(SERVE, 0, 1, 0, 0, 0, 0, 0));
    cyc_chk(0, 1, 0, 512, "serve_pulse_end", snap(SERVE, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 512);
    cyc(0, 1, 0, 512);
    cyc_chk(1, 0, 0, 512, "serve_tick1", snap(SERVE, 0, 0, 0, 0, 0, 0, 0));
    cyc_chk(1, 0, 0, 512, "play_entry", snap(PLAY, 1, 0, 0, 0, 0, 0, 0));

    // right goal, point, next serve
    cyc_chk(1, 0, 0, 1023, "goal_right", snap(POINT, 0, 0, 0, 1, 0, 0, 0));
    cyc(1, 0, 0, 512);
    cyc(1, 0, 0, 512);
    cyc_chk(1, 0, 0, 512, "point_to_serve", snap(SERVE, 0, 1, 0, 1, 0, 0, 0));
    cyc(1, 0, 0, 512);
    cyc_chk(1, 0, 0, 512, "replay", snap(PLAY, 1, 0, 0, 1, 0, 0, 0));

    // three left goals end the match for player2
    for (int i = 1; i <= 3; i++) begin
      cyc_chk(1, 0, 0, 0, "goal_left", snap(POINT, 0, 0, 1, 1, 4'(i), 0, 0));
      cyc(1, 0, 0, 512);
      cyc(1, 0, 0, 512);
      if (i < 3) begin
        cyc_chk(1, 0, 0, 512, "serve_again", snap(SERVE, 0, 1, 1, 1, 4'(i), 0, 0));
        cyc(1, 0, 0, 512);
        cyc_chk(1, 0, 0, 512, "play_again", snap(PLAY, 1, 0, 1, 1, 4'(i), 0, 0));
      end else begin
        cyc_chk(1, 0, 0, 512, "game_over", snap(GAME_OVER, 0, 0, 1, 1, 3, 1, 1));
      end
    end
    cyc_chk(1, 0, 1, 0, "game_over_hold", snap(GAME_OVER, 0, 0, 1, 1, 3, 1, 1));
    cyc(0, 1, 0, 512);
    cyc_chk(0, 0, 0, 512, "restart", snap(SERVE, 0, 1, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 512);
    cyc_chk(1, 0, 0, 512, "play2", snap(PLAY, 1, 0, 0, 0, 0, 0, 0));

    // start ignored in PLAY; pause and resume
    cyc(0, 1, 0, 512);
    cyc_chk(0, 0, 0, 512, "start_ignored", snap(PLAY, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 1, 512);
    cyc_chk(0, 0, 0, 512, "pause_enter", snap(PAUSE, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    cyc_chk(0, 0, 0, 512, "pause_hold", snap(PAUSE, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 1, 512);
    cyc_chk(0, 0, 0, 512, "resume", snap(PLAY, 1, 0, 0, 0, 0, 0, 0));

    // goal beats pause on the same cycle
    cyc(0, 0, 1, 512);
    cyc_chk(1, 0, 0, 0, "goal_beats_pause", snap(POINT, 0, 0, 1, 0, 1, 0, 0));
    cyc(1, 0, 0, 512);
    cyc(1, 0, 0, 512);
    cyc_chk(1, 0, 0, 512, "serve3", snap(SERVE, 0, 1, 1, 0, 1, 0, 0));
    cyc(1, 0, 0, 512);
    cyc_chk(1, 0, 0, 512, "play3", snap(PLAY, 1, 0, 1, 0, 1, 0, 0));
    cyc_chk(1, 0, 0, 1023, "goal_right2", snap(POINT, 0, 0, 0, 1, 1, 0, 0));
    cyc(1, 0, 0, 512);
    cyc(1, 0, 0, 512);
    cyc_chk(1, 0, 0, 512, "serve4", snap(SERVE, 0, 1, 0, 1, 1, 0, 0));
    cyc(1, 0, 0, 512);
    cyc_chk(1, 0, 0, 512, "play4", snap(PLAY, 1, 0, 0, 1, 1, 0, 0));
    cyc_chk(1, 0, 0, 0, "goal_left_pt", snap(POINT, 0, 0, 1, 1, 2, 0, 0));
    cyc(1, 0, 0, 512);

    // mid-match reset with start held through release
    rst = 1'b0;
    cyc_chk(0, 1, 0, 512, "mid_reset", snap(IDLE, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc_chk(0, 1, 0, 512, "no_start_after_rst", snap(IDLE, 0, 0, 0, 0, 0, 0, 0));
    end
    cyc(0, 0, 0, 512);

    check_val("sb_drain", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
